// File: rtl/pipe_step_ctrl.sv
// Pipeline sequencer: debug run/step FSM, load-use stall and memory wait
// merged into the per-stage hold vector, plus a saturating advance counter.
module pipe_step_ctrl #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 32
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_run_cmd,
    input  logic              i_step_cmd,
    input  logic              i_halt_cmd,
    input  logic              i_halt_instr,
    input  logic              i_mem_busy,
    input  logic              i_idex_mem2reg,
    input  logic [NB_REG-1:0] i_idex_rt,
    input  logic [NB_REG-1:0] i_ifid_rs,
    input  logic [NB_REG-1:0] i_ifid_rt,
    output logic              o_hold_pc,
    output logic              o_hold_ifid,
    output logic              o_hold_idex,
    output logic              o_hold_exmem,
    output logic              o_hold_memwb,
    output logic              o_bubble_idex,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state;
    logic   hazard;
    logic   adv;

    assign hazard = i_idex_mem2reg
                 && (i_idex_rt != '0)
                 && ((i_idex_rt == i_ifid_rs)
                  || (i_idex_rt == i_ifid_rt));

    // Reset is folded in so every hold is forced while i_reset is low.
    assign adv = i_reset
              && ((state == RUN) || (state == STEP))
              && !i_mem_busy
              && !i_halt_instr;

    assign o_state = state;

    always_comb begin
        o_hold_pc     = 1'b1;
        o_hold_ifid   = 1'b1;
        o_hold_idex   = 1'b1;
        o_hold_exmem  = 1'b1;
        o_hold_memwb  = 1'b1;
        o_bubble_idex = 1'b0;
        if (adv) begin
            o_hold_pc     = hazard;
            o_hold_ifid   = hazard;
            o_hold_idex   = 1'b0;
            o_hold_exmem  = 1'b0;
            o_hold_memwb  = 1'b0;
            o_bubble_idex = hazard;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state         <= IDLE;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            if (adv && (o_cycle_count != {NB_CNT{1'b1}}))
                o_cycle_count <= o_cycle_count + NB_CNT'(1);
            unique case (state)
                IDLE: begin
                    if (i_step_cmd)
                        state <= STEP;
                    else if (i_run_cmd)
                        state <= RUN;
                end
                RUN: begin
                    if (i_halt_instr) begin
                        state    <= DONE;
                        o_halted <= 1'b1;
                    end else if (i_halt_cmd) begin
                        state <= IDLE;
                    end
                end
                STEP: begin
                    if (i_halt_instr) begin
                        state    <= DONE;
                        o_halted <= 1'b1;
                    end else if (!i_mem_busy) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Bench for pipe_step_ctrl: directed scenarios then random stimulus,
// all checked against a mode-flag reference model.
module tb_pipe_step_ctrl;

    localparam int NB_REG = 5;
    localparam int NB_CNT = 6;
    localparam longint CNT_MAX = (64'd1 << NB_CNT) - 1;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_run_cmd;
    logic              i_step_cmd;
    logic              i_halt_cmd;
    logic              i_halt_instr;
    logic              i_mem_busy;
    logic              i_idex_mem2reg;
    logic [NB_REG-1:0] i_idex_rt;
    logic [NB_REG-1:0] i_ifid_rs;
    logic [NB_REG-1:0] i_ifid_rt;
    logic              o_hold_pc;
    logic              o_hold_ifid;
    logic              o_hold_idex;
    logic              o_hold_exmem;
    logic              o_hold_memwb;
    logic              o_bubble_idex;
    logic [1:0]        o_state;
    logic              o_halted;
    logic [NB_CNT-1:0] o_cycle_count;

    pipe_step_ctrl #(
        .NB_REG(NB_REG),
        .NB_CNT(NB_CNT)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .i_run_cmd(i_run_cmd),
        .i_step_cmd(i_step_cmd),
        .i_halt_cmd(i_halt_cmd),
        .i_halt_instr(i_halt_instr),
        .i_mem_busy(i_mem_busy),
        .i_idex_mem2reg(i_idex_mem2reg),
        .i_idex_rt(i_idex_rt),
        .i_ifid_rs(i_ifid_rs),
        .i_ifid_rt(i_ifid_rt),
        .o_hold_pc(o_hold_pc),
        .o_hold_ifid(o_hold_ifid),
        .o_hold_idex(o_hold_idex),
        .o_hold_exmem(o_hold_exmem),
        .o_hold_memwb(o_hold_memwb),
        .o_bubble_idex(o_bubble_idex),
        .o_state(o_state),
        .o_halted(o_halted),
        .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: mode flags and an unbounded-then-clamped counter.
    bit     m_run;
    bit     m_step;
    bit     m_done;
    longint m_cnt;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit exp_adv();
        return i_reset && (m_run || m_step) && !i_mem_busy && !i_halt_instr;
    endfunction

    function automatic bit exp_hazard();
        return i_idex_mem2reg && (i_idex_rt != 0)
            && (i_idex_rt == i_ifid_rs || i_idex_rt == i_ifid_rt);
    endfunction

    function automatic longint exp_state();
        if (m_done) return 3;
        if (m_step) return 2;
        if (m_run)  return 1;
        return 0;
    endfunction

    task automatic model_edge();
        bit a;
        a = exp_adv();
        if (!i_reset) begin
            m_run = 0; m_step = 0; m_done = 0; m_cnt = 0;
            return;
        end
        if (a && m_cnt < CNT_MAX) m_cnt++;
        if (m_done) begin
        end else if (m_run) begin
            if (i_halt_instr) begin m_run = 0; m_done = 1; end
            else if (i_halt_cmd) m_run = 0;
        end else if (m_step) begin
            if (i_halt_instr) begin m_step = 0; m_done = 1; end
            else if (!i_mem_busy) m_step = 0;
        end else begin
            if (i_step_cmd) m_step = 1;
            else if (i_run_cmd) m_run = 1;
        end
    endtask

    task automatic clr_in();
        i_run_cmd = 0; i_step_cmd = 0; i_halt_cmd = 0;
        i_halt_instr = 0; i_mem_busy = 0; i_idex_mem2reg = 0;
        i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0;
    endtask

    // Called just after a rising edge with inputs already set.
    task automatic tick();
        logic [5:0] exp_h;
        bit a, h;
        #2;
        a = exp_adv();
        h = exp_hazard();
        if (!a) exp_h = 6'b111110;
        else    exp_h = {h, h, 1'b0, 1'b0, 1'b0, h};
        check("holds", {o_hold_pc, o_hold_ifid, o_hold_idex,
                        o_hold_exmem, o_hold_memwb, o_bubble_idex}, exp_h);
        @(posedge clk);
        model_edge();
        #1;
        check("state", o_state, exp_state());
        check("halted", o_halted, m_done);
        check("count", o_cycle_count, m_cnt);
    endtask

    task automatic pulse_run();  i_run_cmd = 1;  tick(); i_run_cmd = 0;  endtask
    task automatic pulse_step(); i_step_cmd = 1; tick(); i_step_cmd = 0; endtask
    task automatic pulse_halt(); i_halt_cmd = 1; tick(); i_halt_cmd = 0; endtask

    initial begin
        clr_in();
        i_reset = 0;
        tick();
        tick();
        i_reset = 1;
        repeat (5) tick();
        check("idle_state", o_state, 0);
        check("idle_hold", o_hold_pc, 1);
        check("idle_count", o_cycle_count, 0);

        repeat (3) begin
            pulse_step();
            tick();
        end
        check("step_count", o_cycle_count, 3);

        pulse_run();
        repeat (10) tick();
        pulse_halt();
        tick();
        check("run_count", o_cycle_count, 14);
        check("run_idle", o_state, 0);

        pulse_run();
        i_idex_mem2reg = 1; i_idex_rt = 5; i_ifid_rs = 5;
        #2;
        check("hz_bubble", o_bubble_idex, 1);
        tick();
        tick();
        i_idex_rt = 0;
        tick();
        check("nohz_count", o_cycle_count, 17);
        clr_in();
        pulse_halt();
        tick();

        pulse_step();
        i_mem_busy = 1;
        repeat (3) tick();
        check("busy_state", o_state, 2);
        i_mem_busy = 0;
        tick();
        tick();
        check("busy_count", o_cycle_count, 19);

        pulse_run();
        tick();
        i_halt_instr = 1;
        #2;
        check("hi_freeze", o_hold_memwb, 1);
        tick();
        i_halt_instr = 0;
        pulse_run();
        pulse_step();
        tick();
        check("done_halted", o_halted, 1);
        check("done_state", o_state, 3);
        i_reset = 0;
        tick();
        i_reset = 1;
        check("rst_count", o_cycle_count, 0);
        check("rst_state", o_state, 0);

        pulse_run();
        repeat (70) tick();
        check("sat_count", o_cycle_count, CNT_MAX);
        pulse_halt();

        for (int i = 0; i < 3000; i++) begin
            i_reset        = ($urandom_range(0, 99) != 0);
            i_run_cmd      = ($urandom_range(0, 7) == 0);
            i_step_cmd     = ($urandom_range(0, 7) == 0);
            i_halt_cmd     = ($urandom_range(0, 9) == 0);
            i_halt_instr   = ($urandom_range(0, 59) == 0);
            i_mem_busy     = ($urandom_range(0, 3) == 0);
            i_idex_mem2reg = $urandom_range(0, 1);
            i_idex_rt      = NB_REG'($urandom_range(0, 3));
            i_ifid_rs      = NB_REG'($urandom_range(0, 3));
            i_ifid_rt      = NB_REG'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
